// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters and registers each result
// into a per-requester response slot that has a valid/ready handshake.
// Arbitration is round-robin by default. Defining ALU_ARB_FIXED_PRIO_EN selects
// fixed priority for req0, with a starvation counter that forces a req1 grant.
module alu_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_ctrl,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_ctrl,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    output logic            rsp0_err,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero,
    output logic            rsp1_err
);

    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_INV = 4'b1111;

    logic            r_rsp0_valid;
    logic [XLEN-1:0] r_rsp0_result;
    logic            r_rsp0_zero;
    logic            r_rsp0_err;
    logic            r_rsp1_valid;
    logic [XLEN-1:0] r_rsp1_result;
    logic            r_rsp1_zero;
    logic            r_rsp1_err;

    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;

    // A requester may be served when its slot is empty or draining this cycle
    assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
    assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force1;

    assign w_force1 = (r_starve_cnt == STARVE_MAX);

    // Fixed priority for req0 unless req1 has waited STARVE_LIMIT cycles
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            if (w_force1) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else if (w_elig0) begin
            w_gnt0 = 1'b1;
        end else if (w_elig1) begin
            w_gnt1 = 1'b1;
        end
    end

    // Count consecutive cycles req1 is eligible but loses, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_elig1 || w_gnt1) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end
`else
    logic r_rr_ptr;
    logic w_unused_cfg;

    // The starvation limit only matters for the fixed-priority build
    assign w_unused_cfg = (STARVE_LIMIT == 0);

    // Round-robin: on contention the pointer picks the winner
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            if (r_rr_ptr) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else if (w_elig0) begin
            w_gnt0 = 1'b1;
        end else if (w_elig1) begin
            w_gnt1 = 1'b1;
        end
    end

    // Point at the requester that did not win; hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end
`endif

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Drive the shared ALU from the winner; park on ADD with zero operands when idle
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = CTRL_ADD;
        if (w_gnt0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (w_gnt1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // Response slot 0: capture on accept, otherwise clear valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp0_err    <= 1'b0;
        end else if (w_gnt0) begin
            r_rsp0_valid <= 1'b1;
            if (req0_ctrl == CTRL_INV) begin
                r_rsp0_result <= '0;
                r_rsp0_zero   <= 1'b0;
                r_rsp0_err    <= 1'b1;
            end else begin
                r_rsp0_result <= alu_result;
                r_rsp0_zero   <= alu_zero;
                r_rsp0_err    <= 1'b0;
            end
        end else if (r_rsp0_valid && rsp0_ready) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    // Response slot 1: capture on accept, otherwise clear valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_zero   <= 1'b0;
            r_rsp1_err    <= 1'b0;
        end else if (w_gnt1) begin
            r_rsp1_valid <= 1'b1;
            if (req1_ctrl == CTRL_INV) begin
                r_rsp1_result <= '0;
                r_rsp1_zero   <= 1'b0;
                r_rsp1_err    <= 1'b1;
            end else begin
                r_rsp1_result <= alu_result;
                r_rsp1_zero   <= alu_zero;
                r_rsp1_err    <= 1'b0;
            end
        end else if (r_rsp1_valid && rsp1_ready) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp0_zero   = r_rsp0_zero;
    assign rsp0_err    = r_rsp0_err;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp1_result = r_rsp1_result;
    assign rsp1_zero   = r_rsp1_zero;
    assign rsp1_err    = r_rsp1_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU and a requester
// protocol monitor (valid must be held until accepted).
module tb_alu_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            req0_valid, req0_ready;
    logic [XLEN-1:0] req0_a, req0_b;
    logic [3:0]      req0_ctrl;
    logic            req1_valid, req1_ready;
    logic [XLEN-1:0] req1_a, req1_b;
    logic [3:0]      req1_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_ctrl;
    logic            alu_zero;
    logic            rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic [XLEN-1:0] rsp0_result;
    logic            rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [XLEN-1:0] rsp1_result;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: AND, OR, ADD, SUB, XOR; anything else yields a marker value
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Requester protocol: a pending (valid && !ready) request must stay valid
    logic pend0, pend1;
    always @(posedge clk) begin
        if (!rst_n) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            if (pend0) begin
                checks++;
                assert (req0_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL proto_req0_hold observed=%0b expected=1", req0_valid);
                end
            end
            if (pend1) begin
                checks++;
                assert (req1_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL proto_req1_hold observed=%0b expected=1", req1_valid);
                end
            end
            pend0 = req0_valid && !req0_ready;
            pend1 = req1_valid && !req1_ready;
        end
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = 4'b0010;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = 4'b0010;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step;
        step;
        rst_n = 1'b1;

        // Reset arriving during an accept discards the capture
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010; rsp0_ready = 1'b1;
        #1;
        chk("rst_pre_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        step;
        chk("rst_valid0", 32'(rsp0_valid), 32'd0);
        chk("rst_result0", rsp0_result, 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step;
        chk("rst_post_valid0", 32'(rsp0_valid), 32'd0);
        chk("rst_post_result0", rsp0_result, 32'd0);
        chk("rst_post_valid1", 32'(rsp1_valid), 32'd0);

        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Fixed priority: req0 wins four times, then req1 is forced in
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1; req0_ctrl = 4'b0011;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = 4'b0010;
        for (int k = 0; k < 11; k++) begin
            logic exp1;
            if (k == 10) req1_valid = 1'b0;
            exp1 = (k == 4) || (k == 9);
            #1;
            chk("fp_gnt1", 32'(req1_ready), 32'(exp1));
            chk("fp_gnt0", 32'(req0_ready), 32'(!exp1));
            step;
        end
        req0_valid = 1'b0;
`else
        // Round-robin under continuous contention: 0,1,0,1 then req0 alone
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1; req0_ctrl = 4'b0011;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req1_valid = 1'b0;
            #1;
            chk("rr_gnt0", 32'(req0_ready), 32'(k % 2 == 0));
            chk("rr_gnt1", 32'(req1_ready), 32'(k % 2 == 1));
            chk("rr_alu_a", alu_a, (k % 2 == 0) ? 32'd1 : 32'd10);
            step;
            if (k % 2 == 0) begin
                chk("rr_rsp0_valid", 32'(rsp0_valid), 32'd1);
                chk("rr_rsp0_result", rsp0_result, 32'd0);
                chk("rr_rsp0_zero", 32'(rsp0_zero), 32'd1);
                chk("rr_rsp1_idle", 32'(rsp1_valid), 32'd0);
            end else begin
                chk("rr_rsp1_valid", 32'(rsp1_valid), 32'd1);
                chk("rr_rsp1_result", rsp1_result, 32'd14);
                chk("rr_rsp1_zero", 32'(rsp1_zero), 32'd0);
                chk("rr_rsp0_idle", 32'(rsp0_valid), 32'd0);
            end
        end
        req0_valid = 1'b0;

        // Fill slot 1 and hold it with backpressure
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd3; req1_ctrl = 4'b0011;
        #1;
        chk("bp_fill_ready1", 32'(req1_ready), 32'd1);
        step;
        chk("bp_fill_valid1", 32'(rsp1_valid), 32'd1);
        chk("bp_fill_result1", rsp1_result, 32'd17);

        // Slot 1 full: req1 blocked, req0 served every cycle
        req1_a = 32'd8; req1_b = 32'd8; req1_ctrl = 4'b0011;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_ctrl = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_ready0", 32'(req0_ready), 32'd1);
            step;
            chk("bp_hold_valid1", 32'(rsp1_valid), 32'd1);
            chk("bp_hold_result1", rsp1_result, 32'd17);
            chk("bp_valid0", 32'(rsp0_valid), 32'd1);
            chk("bp_result0", rsp0_result, 32'd5);
        end

        // Releasing backpressure lets req1 in the same cycle; slot replaced in place
        rsp1_ready = 1'b1;
        #1;
        chk("bp_rel_ready1", 32'(req1_ready), 32'd1);
        chk("bp_rel_ready0", 32'(req0_ready), 32'd0);
        step;
        chk("bp_rel_valid1", 32'(rsp1_valid), 32'd1);
        chk("bp_rel_result1", rsp1_result, 32'd0);
        chk("bp_rel_zero1", 32'(rsp1_zero), 32'd1);
        chk("bp_rel_drain0", 32'(rsp0_valid), 32'd0);
        req1_valid = 1'b0;
        #1;
        chk("bp_tail_ready0", 32'(req0_ready), 32'd1);
        step;
        chk("bp_tail_result0", rsp0_result, 32'd5);
        req0_valid = 1'b0;
`endif

        // Single requester: same-cycle grant, one-cycle response
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd5; req0_ctrl = 4'b0011;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_alu_a", alu_a, 32'd7);
        chk("single_alu_b", alu_b, 32'd5);
        chk("single_alu_ctrl", 32'(alu_ctrl), 32'd3);
        step;
        chk("single_valid0", 32'(rsp0_valid), 32'd1);
        chk("single_result0", rsp0_result, 32'd2);
        chk("single_zero0", 32'(rsp0_zero), 32'd0);
        chk("single_err0", 32'(rsp0_err), 32'd0);
        req0_valid = 1'b0;
        #1;
        chk("idle_alu_ctrl", 32'(alu_ctrl), 32'd2);
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_ready0", 32'(req0_ready), 32'd0);
        step;
        chk("drain_valid0", 32'(rsp0_valid), 32'd0);
        chk("drain_hold_result0", rsp0_result, 32'd2);

        // Invalid control code
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 4'b1111;
        #1;
        chk("inv_ready0", 32'(req0_ready), 32'd1);
        step;
        chk("inv_valid0", 32'(rsp0_valid), 32'd1);
        chk("inv_err0", 32'(rsp0_err), 32'd1);
        chk("inv_result0", rsp0_result, 32'd0);
        chk("inv_zero0", 32'(rsp0_zero), 32'd0);
        req0_valid = 1'b0;
        #1;
        chk("inv_idle_alu_ctrl", 32'(alu_ctrl), 32'd2);
        chk("inv_idle_alu_a", alu_a, 32'd0);
        step;
        chk("inv_drain_valid0", 32'(rsp0_valid), 32'd0);
        chk("inv_drain_err0", 32'(rsp0_err), 32'd1);

        // A legal op clears the error flag
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_ctrl = 4'b0010;
        step;
        chk("clr_valid0", 32'(rsp0_valid), 32'd1);
        chk("clr_result0", rsp0_result, 32'd7);
        chk("clr_err0", 32'(rsp0_err), 32'd0);
        req0_valid = 1'b0;
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
